// File: rtl/seq_det_pkg.sv
// Shared encodings for the 101 detector and its round-robin scheduler.
// Build option SEQ_DET_SCHED_OVERLAP_EN is consumed by seq_det_core.
package seq_det_pkg;

    typedef logic [1:0] det_state_t;
    localparam det_state_t S0 = 2'b00;
    localparam det_state_t S1 = 2'b01;
    localparam det_state_t S2 = 2'b10;

    typedef logic [1:0] sched_state_t;
    localparam sched_state_t IDLE  = 2'b00;
    localparam sched_state_t SHIFT = 2'b01;
    localparam sched_state_t RESP  = 2'b10;

endpackage

// File: rtl/seq_det_core.sv
// Mealy 101 detector with synchronous clear and bit enable.
// SEQ_DET_SCHED_OVERLAP_EN: a detect returns to S1 instead of S0.
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic y
);

    det_state_t state;
    det_state_t state_nxt;

    always_comb begin
        state_nxt = state;
        y         = 1'b0;
        if (clr) begin
            state_nxt = S0;
        end else if (en) begin
            case (state)
                S0: state_nxt = x ? S1 : S0;
                S1: state_nxt = x ? S1 : S2;
                S2: begin
                    if (x) begin
                        y = 1'b1;
`ifdef SEQ_DET_SCHED_OVERLAP_EN
                        // Trailing 1 of this match seeds the next one.
                        state_nxt = S1;
`else
                        state_nxt = S0;
`endif
                    end else begin
                        state_nxt = S0;
                    end
                end
                default: state_nxt = S0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

endmodule

// File: rtl/seq_det_101_sched.sv
// Round-robin scheduler sharing one 101 detector among NREQ requesters;
// each word is shifted MSB-first and its detection count returned with the id.
module seq_det_101_sched
    import seq_det_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ),
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                  rst,
    input  logic                  clk,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [CNT_W-1:0]      rsp_count,
    output logic                  busy
);

    sched_state_t     state;
    logic [IDW-1:0]   last_grant;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] grant_word;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             det_en;
    logic             det_y;

    // Round-robin search begins one past the previous winner.
    always_comb begin
        int       idx_int;
        logic [IDW-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx_int = (int'(last_grant) + i) % NREQ;
            idx     = IDW'(idx_int);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    assign grant_word = req_data[int'(grant_idx)*WIDTH +: WIDTH];
    assign accept     = rst && (state == IDLE) && grant_found;
    assign det_en     = (state == SHIFT);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    seq_det_core u_core (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (det_en),
        .x   (shift_reg[WIDTH-1]),
        .y   (det_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            shift_reg  <= '0;
            bit_cnt    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_count  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        shift_reg  <= grant_word;
                        rsp_id     <= grant_idx;
                        last_grant <= grant_idx;
                        bit_cnt    <= '0;
                        rsp_count  <= '0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                    if (det_y) begin
                        rsp_count <= rsp_count + CNT_W'(1);
                    end
                    // Last bit: the final detect lands in rsp_count on this same edge.
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
